// File: rtl/mem_refill_responder.sv
// Line-granular backing-store responder: fixed-latency refill bursts and writeback bursts.
// Optional macro MEM_RESP_ALIGN_CHECK_EN rejects misaligned requests with an err_o pulse.
module mem_refill_responder #(
  parameter int LINE_WORDS   = 8,
  parameter int MEM_ADDR_LEN = 12,
  parameter int LATENCY      = 50
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [31:0] req_addr_i,
  input  logic        wr_valid_i,
  input  logic [31:0] wr_data_i,
  output logic        wr_ready_o,
  output logic        rd_valid_o,
  output logic [31:0] rd_data_o,
  output logic        rd_last_o,
  output logic        busy_o,
  output logic        err_o,
  output logic [1:0]  fsm_state
);
  // Handshakes: a request is taken on a rising edge where req_valid_i && req_ready_o;
  // a write beat is taken where wr_valid_i && wr_ready_o; read beats have no backpressure.
  localparam int BW = $clog2(LINE_WORDS);
  localparam int CW = $clog2(LATENCY);
  localparam int AW = MEM_ADDR_LEN;

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RBURST = 2'd2, WBURST = 2'd3} state_t;

  state_t          state, state_d;
  logic            we_q;
  logic [AW-1:0]   base_q;
  logic [BW-1:0]   beat_q;
  logic [BW-1:0]   beat_nxt;
  logic [CW-1:0]   cnt_q;
  logic [AW-1:0]   req_base;
  logic            hs;
  logic            misaligned;
  logic            accept;
  logic            beat_last;
  logic [BW-1:0]   rd_beat;
  logic [AW-1:0]   rd_addr;
  logic [AW-1:0]   wr_addr;
  logic            mem_we;
  logic            err_d;
  logic            unused_addr;
  logic [31:0]     mem [0:(1<<AW)-1];

  assign fsm_state = state;
  assign req_base  = {req_addr_i[AW+1:BW+2], {BW{1'b0}}};
  assign hs        = (state == IDLE) && req_valid_i;
  assign accept    = hs && !misaligned;
  assign beat_nxt  = beat_q + BW'(1);
  assign beat_last = (beat_q == BW'(LINE_WORDS - 1));

`ifdef MEM_RESP_ALIGN_CHECK_EN
  assign misaligned  = |req_addr_i[BW+1:0];
  assign unused_addr = ^req_addr_i[31:AW+2];
`else
  assign misaligned  = 1'b0;
  assign unused_addr = ^{req_addr_i[31:AW+2], req_addr_i[BW+1:0]};
`endif

  // State register and per-request datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      we_q   <= 1'b0;
      base_q <= '0;
      beat_q <= '0;
      cnt_q  <= '0;
    end else begin
      state <= state_d;
      if (accept) begin
        we_q   <= req_we_i;
        base_q <= req_base;
        beat_q <= '0;
        cnt_q  <= CW'(LATENCY - 2);
      end
      if (state == WAIT && cnt_q != '0) cnt_q <= cnt_q - CW'(1);
      if (state == RBURST || mem_we) beat_q <= beat_nxt;
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (accept) state_d = WAIT;
      WAIT:    if (cnt_q == '0) state_d = we_q ? WBURST : RBURST;
      RBURST:  if (beat_last) state_d = IDLE;
      WBURST:  if (wr_valid_i && beat_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Read address is presented one cycle ahead of the beat it produces
  always_comb begin
    rd_beat = '0;
    err_d   = 1'b0;
    if (state == RBURST) rd_beat = beat_nxt;
    rd_addr = base_q + AW'(rd_beat);
    wr_addr = base_q + AW'(beat_q);
    mem_we  = (state == WBURST) && wr_valid_i;
    if (hs && misaligned) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_ready_o <= 1'b1;
      busy_o      <= 1'b0;
      wr_ready_o  <= 1'b0;
      rd_valid_o  <= 1'b0;
      rd_last_o   <= 1'b0;
      rd_data_o   <= '0;
    end else begin
      req_ready_o <= (state_d == IDLE);
      busy_o      <= (state_d != IDLE);
      wr_ready_o  <= (state_d == WBURST);
      rd_valid_o  <= (state_d == RBURST);
      rd_last_o   <= (state_d == RBURST) && (rd_beat == BW'(LINE_WORDS - 1));
      rd_data_o   <= (state_d == RBURST) ? mem[rd_addr] : '0;
    end
  end

`ifdef MEM_RESP_ALIGN_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_o <= 1'b0;
    else        err_o <= err_d;
  end
`else
  assign err_o = 1'b0;
`endif

  // Storage is never reset so contents survive rst_n
  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_addr] <= wr_data_i;
  end
endmodule

// File: doc/mem_refill_responder.md
# mem_refill_responder

Backing-store responder on the far side of the data cache's miss interface: it accepts one line-granular request at a time from the cache controller and serves it after a fixed access latency. A line refill returns as a burst of read beats; a dirty-line writeback is taken in as a burst of write beats. The block models main memory for the RV32 core's cache configuration and sits between the cache and nothing else.

## Interface
- `LINE_WORDS`, default 8 — 32-bit words per cache line; power of two, minimum 2.
- `MEM_ADDR_LEN`, default 12 — log2 of storage depth in words.
- `LATENCY`, default 50 — cycles from request handshake to first data beat; minimum 2.

- `clk` — input, 1 — single clock; all logic is on the rising edge.
- `rst_n` — input, 1 — asynchronous, active-low reset.
- `req_valid_i` — input, 1 — request present.
- `req_ready_o` — output, 1 — responder idle and able to accept a request.
- `req_we_i` — input, 1 — 1 = writeback, 0 = refill.
- `req_addr_i` — input, 32 — byte address of the line.
- `wr_valid_i` — input, 1 — write beat present.
- `wr_data_i` — input, 32 — write beat data.
- `wr_ready_o` — output, 1 — write beat accepted this cycle when `wr_valid_i` is high.
- `rd_valid_o` — output, 1 — read beat valid; no backpressure.
- `rd_data_o` — output, 32 — read beat data.
- `rd_last_o` — output, 1 — final read beat of the line.
- `busy_o` — output, 1 — inverse of `req_ready_o`.
- `err_o` — output, 1 — one-cycle pulse when a request is rejected (see Configuration).

## Operation
- Storage: 2^`MEM_ADDR_LEN` 32-bit words. Contents are not reset and are preserved across reset.
- Word index is `req_addr_i[MEM_ADDR_LEN+1:2]`. Higher address bits are ignored, so addresses wrap modulo storage size.
- The line base clears the low log2(`LINE_WORDS`)+2 address bits. Beat k addresses line base + k.
- FSM states:
  - IDLE: `req_ready_o`=1. On handshake, latch we/base address, load the latency counter, and go to WAIT.
  - WAIT: count down `LATENCY` cycles, then go to RBURST or WBURST according to the latched we.
  - RBURST: emit exactly `LINE_WORDS` beats on consecutive cycles. `rd_last_o` is asserted with beat `LINE_WORDS`-1. Return to IDLE after the last beat.
  - WBURST: `wr_ready_o`=1. Each cycle with `wr_valid_i`=1 writes one beat, in order. Gaps in `wr_valid_i` stall the burst indefinitely; there is no timeout. After beat `LINE_WORDS`-1 is accepted, return to IDLE.
- `wr_valid_i` outside WBURST is ignored. `req_valid_i` outside IDLE is ignored; the requester holds it.
- A write to a line is fully committed before a subsequent read request can be accepted, so read-after-write returns the new data.
- Beat counter is log2(`LINE_WORDS`) bits; word address increment wraps within storage.

## Timing
- Reset values: `req_ready_o`=1, `busy_o`=0, `wr_ready_o`=0, `rd_valid_o`=0, `rd_last_o`=0, `rd_data_o`=0, `err_o`=0; FSM in IDLE.
- Request handshake in cycle T:
  - Refill: `rd_valid_o` is high in cycles T+`LATENCY` through T+`LATENCY`+`LINE_WORDS`-1, and `req_ready_o` returns high at T+`LATENCY`+`LINE_WORDS`.
  - Writeback: `wr_ready_o` rises at T+`LATENCY`. With `wr_valid_i` held high, `req_ready_o` returns high at T+`LATENCY`+`LINE_WORDS`.
- All outputs are registered. Storage uses a synchronous read; the first read is issued one cycle before the first beat.
- Reset asserted mid-burst: outputs go to reset values immediately (asynchronously). Any partial writeback already written stays in storage.

## Configuration
- `MEM_RESP_ALIGN_CHECK_EN` defined:
  - A request whose low log2(`LINE_WORDS`)+2 address bits are non-zero is consumed in IDLE. The block pulses `err_o` for one cycle (the cycle after the handshake) and stays in IDLE: no burst, no storage change.
- Not defined: those bits are silently cleared, and `err_o` is tied to 0.

## Test plan
- Reset, then writeback to 0x100 with beats 0xA0..0xA7 (`LATENCY`=4), then refill 0x100 → `wr_ready_o` rises at T+4; refill beats 0xA0..0xA7 at T'+4..T'+11; `rd_last_o` is high only with 0xA7.
- Writeback with `wr_valid_i` low for 3 cycles mid-burst → burst stalls; all 8 words land in order; `req_ready_o` returns high only after beat 7.
- Back-to-back: `req_valid_i` held high for refill 0x0 then refill 0x20 → second handshake occurs in the cycle `req_ready_o` rises; no beat overlap; 16 total beats.
- Address wrap with `MEM_ADDR_LEN`=12: write to 0x4000_0100, refill from 0x100 → same data returned.
- Misaligned refill 0x104: with macro → `err_o` pulse, no `rd_valid_o`, `req_ready_o` stays 1. Without macro → line 0x100 returned.
- `rst_n` low during beat 3 of a refill → `rd_valid_o`=0 immediately; after release, FSM is IDLE and a new refill returns correct data.
